// File: rtl/add_seq_pkg.sv
// Shared definitions for the nibble-serial add sequencer.
//   NIB_W   : width of one adder pass (the shared slice width)
//   state_t : controller FSM encoding (IDLE=0, RUN=1, DONE=2)
package add_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_ctrl_add.sv
// 4-bit ripple adder slice shared by the sequencer, one pass per nibble.
// Ports:
//   a, b  in  [3:0]  addend nibbles
//   cin   in         carry in
//   sum   out [3:0]  nibble sum
//   cout  out        carry out
module add
  import add_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor controller. Latches operands on an
// in_valid/in_ready handshake, runs the shared 4-bit slice once per nibble
// (LSB first, carry chained through a register), then presents the result on
// an out_valid/out_ready handshake.
// Optional feature macro: ADD_SEQ_SUB_EN adds the in_sub port; a latched
// sub=1 inverts every B nibble and starts with carry = ~in_cin (A - B - cin).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake
//   in_a, in_b, in_cin   operands and LSB carry in
//   in_sub               subtract select (ADD_SEQ_SUB_EN only)
//   out_valid/out_ready  result handshake
//   out_sum, out_cout    result and MSB carry out
//   out_ovf              signed two's-complement overflow
//   busy                 high in RUN and DONE
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = $clog2(NIBBLES);

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
`ifdef ADD_SEQ_SUB_EN
  logic               sub_r;
`endif

  logic [NIB_W-1:0]   nib_a_s;
  logic [NIB_W-1:0]   nib_b_s;
  logic [NIB_W-1:0]   slice_sum_s;
  logic               slice_cout_s;
  logic               msb_cin_s;
  logic               start_carry_s;

  // Select the current operand nibbles (B inverted when subtracting) and the initial carry.
  always_comb begin
    nib_a_s       = a_r[NIB_W*idx_r +: NIB_W];
    nib_b_s       = b_r[NIB_W*idx_r +: NIB_W];
    start_carry_s = in_cin;
`ifdef ADD_SEQ_SUB_EN
    if (sub_r) begin
      nib_b_s = ~b_r[NIB_W*idx_r +: NIB_W];
    end else begin
      nib_b_s = b_r[NIB_W*idx_r +: NIB_W];
    end
    if (in_sub) begin
      start_carry_s = ~in_cin;
    end else begin
      start_carry_s = in_cin;
    end
`endif
  end

  // Carry into the slice MSB recovered from its sum bit; only meaningful on the last nibble.
  assign msb_cin_s = nib_a_s[NIB_W-1] ^ nib_b_s[NIB_W-1] ^ slice_sum_s[NIB_W-1];

  add u_add (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Controller FSM: operand capture, per-nibble accumulation, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      carry_r   <= 1'b0;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
`ifdef ADD_SEQ_SUB_EN
      sub_r     <= 1'b0;
`endif
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= {WIDTH{1'b0}};
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
`ifdef ADD_SEQ_SUB_EN
            sub_r    <= in_sub;
`endif
            carry_r  <= start_carry_s;
            idx_r    <= {IDX_W{1'b0}};
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          out_sum[NIB_W*idx_r +: NIB_W] <= slice_sum_s;
          carry_r <= slice_cout_s;
          idx_r   <= idx_r + IDX_W'(1);
          if (idx_r == IDX_W'(NIBBLES - 1)) begin
            out_cout  <= slice_cout_s;
            out_ovf   <= msb_cin_s ^ slice_cout_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r   <= RUN;
          end
        end
        DONE: begin
          // Return to IDLE only; the next accept can happen one cycle later.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (WIDTH=16): table-driven operations
// plus hand-written backpressure and mid-RUN reset sequences.
module tb_add_seq_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef ADD_SEQ_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int checks;
  int failures;

  add_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADD_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready (bounded), present operands for one accept edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef ADD_SEQ_SUB_EN
    in_sub   = sub;
`else
    if (sub) $display("note: subtract vector applied without ADD_SEQ_SUB_EN");
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles from accept edge until out_valid (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] held;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_cin    = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    in_sub    = 1'b0;
`endif

    vecs.push_back('{16'h0006, 16'h0003, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
`ifdef ADD_SEQ_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0});
`endif

    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum",   {16'd0, out_sum},   32'd0);
    check("rst_out_cout",  {31'd0, out_cout},  32'd0);
    check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);

    // Table-driven operations
    for (int i = 0; i < vecs.size(); i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      check($sformatf("v%0d_in_ready_run", i), {31'd0, in_ready}, 32'd0);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), lat, 32'd4);
      check($sformatf("v%0d_sum", i),  {16'd0, out_sum},  {16'd0, vecs[i].sum});
      check($sformatf("v%0d_cout", i), {31'd0, out_cout}, {31'd0, vecs[i].cout});
      check($sformatf("v%0d_ovf", i),  {31'd0, out_ovf},  {31'd0, vecs[i].ovf});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_valid_drop", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("v%0d_ready_back", i), {31'd0, in_ready},  32'd1);
      check($sformatf("v%0d_sum_kept", i), {16'd0, out_sum}, {16'd0, vecs[i].sum});
    end

    // Backpressure with in_valid held high; operand changes mid-RUN must be ignored
    accept(16'h1111, 16'h2222, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_a     = 16'hAAAA;
    in_b     = 16'h5555;
    wait_valid(lat);
    check("bp_latency", lat, 32'd4);
    check("bp_sum", {16'd0, out_sum}, 32'h3333);
    held = out_sum;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold%0d_sum", k),   {16'd0, out_sum},  {16'd0, held});
      check($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold%0d_ready", k), {31'd0, in_ready},  32'd0);
    end
    in_a      = 16'h0001;
    in_b      = 16'h0002;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_after_hs_valid", {31'd0, out_valid}, 32'd0);
    check("bp_after_hs_ready", {31'd0, in_ready},  32'd1);
    check("bp_after_hs_busy",  {31'd0, busy},      32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_resume_ready", {31'd0, in_ready}, 32'd0);
    check("bp_resume_busy",  {31'd0, busy},     32'd1);
    wait_valid(lat);
    check("bp_resume_latency", lat, 32'd4);
    check("bp_resume_sum", {16'd0, out_sum}, 32'h0003);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the second RUN cycle aborts the operation
    accept(16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_sum",   {16'd0, out_sum},   32'd0);
    check("abort_busy",      {31'd0, busy},      32'd0);
    check("abort_out_cout",  {31'd0, out_cout},  32'd0);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) lat++;
    end
    check("abort_no_result", lat, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
